// File: rtl/clock_step_ctrl.sv
// Run / pause / single-step clock-enable controller with enabled-cycle counter.
// Optional stall watchdog is built only when CLK_STEP_WATCHDOG_EN is defined.
module clock_step_ctrl #(
    parameter int CNT_W  = 32,
    parameter int WDOG_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic             fifo_afull_i,
    output logic             data_next_o,
    output logic             done_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] remain_o,
    output logic [63:0]      cycle_cnt_o,
    output logic             stall_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_PAUSE = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    state_t           state_p0, state_p1;
    logic [CNT_W-1:0] remain_p0, remain_p1;
    logic             data_next_p0, data_next_p1;
    logic             done_p0, done_p1;
    logic [63:0]      cycle_cnt_p1;
    logic             cmd_acc;
    logic             clr_cnt;
    logic             final_cyc;

    assign cmd_ready_o = ~rst_i;
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign clr_cnt     = cmd_acc && (cmd_op_i == OP_CLR);
    assign final_cyc   = (state_p1 == ST_STEP) && data_next_p1 && (remain_p1 == CNT_W'(1));

    // Stage 0: next state; a command accepted this cycle overrides step completion
    always_comb begin
        state_p0  = state_p1;
        remain_p0 = remain_p1;
        done_p0   = 1'b0;
        if ((state_p1 == ST_STEP) && data_next_p1) begin
            remain_p0 = remain_p1 - CNT_W'(1);
        end
        if (final_cyc) begin
            state_p0 = ST_IDLE;
            done_p0  = 1'b1;
        end
        if (cmd_acc) begin
            case (cmd_op_i)
                OP_PAUSE: begin
                    state_p0  = ST_IDLE;
                    remain_p0 = '0;
                end
                OP_RUN: begin
                    state_p0  = ST_RUN;
                    remain_p0 = '0;
                end
                OP_STEP: begin
                    if (cmd_cnt_i == '0) begin
                        state_p0  = ST_IDLE;
                        remain_p0 = '0;
                        done_p0   = 1'b1;
                    end else begin
                        state_p0  = ST_STEP;
                        remain_p0 = cmd_cnt_i;
                    end
                end
                default: ;
            endcase
        end
        data_next_p0 = (state_p0 != ST_IDLE) && !fifo_afull_i;
    end

    // Stage 1: registered control and outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p1     <= ST_IDLE;
            remain_p1    <= '0;
            data_next_p1 <= 1'b0;
            done_p1      <= 1'b0;
            cycle_cnt_p1 <= '0;
        end else begin
            state_p1     <= state_p0;
            remain_p1    <= remain_p0;
            data_next_p1 <= data_next_p0;
            done_p1      <= done_p0;
            if (clr_cnt) begin
                cycle_cnt_p1 <= '0;
            end else if (data_next_p1) begin
                cycle_cnt_p1 <= cycle_cnt_p1 + 64'd1;
            end
        end
    end

`ifdef CLK_STEP_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    logic [WDOG_W-1:0] wdog_p0, wdog_p1;
    logic              stall_err_p1;

    // Counter saturates so the error keeps re-asserting after a clear while still stalled
    always_comb begin
        wdog_p0 = '0;
        if (((state_p1 == ST_RUN) || (state_p1 == ST_STEP)) && fifo_afull_i) begin
            wdog_p0 = (wdog_p1 == WDOG_MAX) ? WDOG_MAX : wdog_p1 + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_p1      <= '0;
            stall_err_p1 <= 1'b0;
        end else begin
            wdog_p1 <= wdog_p0;
            if (clr_cnt) begin
                stall_err_p1 <= 1'b0;
            end else if (wdog_p0 == WDOG_MAX) begin
                stall_err_p1 <= 1'b1;
            end
        end
    end

    assign stall_err_o = stall_err_p1;
`else
    assign stall_err_o = 1'b0;
`endif

    assign data_next_o = data_next_p1;
    assign done_o      = done_p1;
    assign state_o     = state_p1;
    assign remain_o    = remain_p1;
    assign cycle_cnt_o = cycle_cnt_p1;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Randomized and directed bench for clock_step_ctrl against a behavioural model.
// Define CLK_STEP_WATCHDOG_EN to also cover the watchdog (instantiated with WDOG_W=4).
module tb_clock_step_ctrl;

`ifdef CLK_STEP_WATCHDOG_EN
    localparam int WD = 4;
`else
    localparam int WD = 16;
`endif
    localparam int WMAX = (1 << WD) - 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_cnt_i = '0;
    logic        fifo_afull_i = 1'b0;
    logic        data_next_o;
    logic        done_o;
    logic [1:0]  state_o;
    logic [31:0] remain_o;
    logic [63:0] cycle_cnt_o;
    logic        stall_err_o;

    clock_step_ctrl #(.CNT_W(32), .WDOG_W(WD)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_cnt_i    (cmd_cnt_i),
        .fifo_afull_i (fifo_afull_i),
        .data_next_o  (data_next_o),
        .done_o       (done_o),
        .state_o      (state_o),
        .remain_o     (remain_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .stall_err_o  (stall_err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // reference model: mode, steps left, enable applied this cycle, counters
    int          m_state = 0;
    logic [31:0] m_rem   = '0;
    bit          m_en    = 0;
    bit          m_done  = 0;
    logic [63:0] m_cnt   = '0;
    bit          m_err   = 0;
    int          m_wdog  = 0;
    longint      target  = 0;
    longint      seen    = 0;
    int          en_tally = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rem = '0; m_en = 0; m_done = 0;
        m_cnt = '0; m_err = 0; m_wdog = 0; target = 0; seen = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] op, input logic [31:0] n, input bit af);
        int          ns;
        logic [31:0] nr;
        bit          nd;
        bit          en;
        en = m_en;
        ns = m_state;
        nr = m_rem;
        nd = 0;
        if (m_state == 2 && en) nr = m_rem - 1;
        if (m_state == 2 && en && m_rem == 1) begin
            ns = 0;
            nd = 1;
            check("step_len", 64'(seen), 64'(target));
        end
`ifdef CLK_STEP_WATCHDOG_EN
        if ((m_state == 1 || m_state == 2) && af) m_wdog = (m_wdog == WMAX) ? WMAX : m_wdog + 1;
        else m_wdog = 0;
`endif
        if (v) begin
            case (op)
                2'd0: begin ns = 0; nr = '0; end
                2'd1: begin ns = 1; nr = '0; end
                2'd2: begin
                    if (n == 0) begin ns = 0; nr = '0; nd = 1; end
                    else begin ns = 2; nr = n; target = longint'(n); seen = 0; end
                end
                default: ;
            endcase
        end
        if (v && op == 2'd3) m_cnt = '0;
        else m_cnt = m_cnt + 64'(en);
`ifdef CLK_STEP_WATCHDOG_EN
        if (v && op == 2'd3) m_err = 0;
        else if (m_wdog == WMAX) m_err = 1;
`endif
        m_en    = (ns != 0) && !af;
        m_state = ns;
        m_rem   = nr;
        m_done  = nd;
    endtask

    task automatic check_all();
        check("state", 64'(state_o), 64'(m_state));
        check("remain", 64'(remain_o), 64'(m_rem));
        check("data_next", 64'(data_next_o), 64'(m_en));
        check("done", 64'(done_o), 64'(m_done));
        check("cycle_cnt", cycle_cnt_o, m_cnt);
        check("stall_err", 64'(stall_err_o), 64'(m_err));
        check("ready", 64'(cmd_ready_o), 64'd1);
    endtask

    task automatic cyc(input bit v, input logic [1:0] op, input logic [31:0] n, input bit af);
        cmd_valid_i  = v;
        cmd_op_i     = op;
        cmd_cnt_i    = n;
        fifo_afull_i = af;
        @(posedge clk_i);
        model_edge(v, op, n, af);
        #1;
        check_all();
        if (data_next_o) begin
            seen++;
            en_tally++;
        end
    endtask

    task automatic idle(input int k, input bit af);
        for (int i = 0; i < k; i++) cyc(0, 2'd0, '0, af);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // reset values
        #1;
        check("rst_ready", 64'(cmd_ready_o), 64'd0);
        check("rst_data_next", 64'(data_next_o), 64'd0);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_cnt", cycle_cnt_o, 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // STEP 5
        en_tally = 0;
        cyc(1, 2'd2, 32'd5, 0);
        check("s5_first_en", 64'(data_next_o), 64'd1);
        idle(4, 0);
        check("s5_last_remain", 64'(remain_o), 64'd1);
        cyc(0, 2'd0, '0, 0);
        check("s5_done", 64'(done_o), 64'd1);
        check("s5_off", 64'(data_next_o), 64'd0);
        idle(3, 0);
        check("s5_tally", 64'(en_tally), 64'd5);
        check("s5_cnt", cycle_cnt_o, 64'd5);

        // STEP 10 with a 3-cycle backpressure gap after 4 enables
        cyc(1, 2'd3, '0, 0);
        check("clr_cnt", cycle_cnt_o, 64'd0);
        en_tally = 0;
        cyc(1, 2'd2, 32'd10, 0);
        idle(3, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'd0, '0, 1);
            check("s10_gap_remain", 64'(remain_o), 64'd6);
            check("s10_gap_en", 64'(data_next_o), 64'd0);
        end
        idle(8, 0);
        check("s10_tally", 64'(en_tally), 64'd10);

        // RUN 20 cycles, PAUSE, STEP 0
        cyc(1, 2'd3, '0, 0);
        cyc(1, 2'd1, '0, 0);
        idle(19, 0);
        cyc(1, 2'd0, '0, 0);
        check("run_cnt", cycle_cnt_o, 64'd20);
        cyc(1, 2'd2, 32'd0, 0);
        check("s0_done", 64'(done_o), 64'd1);
        check("s0_en", 64'(data_next_o), 64'd0);
        idle(2, 0);
        check("s0_cnt", cycle_cnt_o, 64'd20);

`ifdef CLK_STEP_WATCHDOG_EN
        cyc(1, 2'd1, '0, 0);
        idle(15, 1);
        check("wdog_set", 64'(stall_err_o), 64'd1);
        cyc(1, 2'd3, '0, 0);
        check("wdog_clr", 64'(stall_err_o), 64'd0);
        cyc(1, 2'd0, '0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            logic [1:0]  op;
            logic [31:0] n;
            v  = ($urandom_range(0, 5) == 0);
            op = 2'($urandom_range(0, 3));
            n  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 6));
            cyc(v, op, n, $urandom_range(0, 3) == 0);
        end

        // STEP 100 aborted by asynchronous reset after 30 enables
        cyc(1, 2'd3, '0, 0);
        cyc(1, 2'd2, 32'd100, 0);
        idle(30, 0);
        check("abort_remain_pre", 64'(remain_o), 64'd70);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("abort_en", 64'(data_next_o), 64'd0);
        check("abort_remain", 64'(remain_o), 64'd0);
        check("abort_state", 64'(state_o), 64'd0);
        check("abort_ready", 64'(cmd_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("abort_done", 64'(done_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(3, 0);
        cyc(1, 2'd1, '0, 0);
        idle(4, 0);
        check("post_rst_cnt", cycle_cnt_o, 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
